// File: rtl/siso_seq_pkg.sv
// Shared definitions for serial shift-chain sequencers: state encoding and
// default word width / chain latency.
package siso_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_LAT   = 4;

    // Counter must reach WIDTH+LAT-1 without wrapping.
    function automatic int cnt_width(input int width, input int lat);
        return $clog2(width + lat + 1);
    endfunction

endpackage

// File: rtl/siso_seq_cnt.sv
// Shift-cycle counter: synchronous clear/enable up-counter whose terminal
// flag marks the last SHIFT cycle (WIDTH+LAT-1).
module siso_seq_cnt
    import siso_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LAT   = DEF_LAT,
    parameter int CW    = cnt_width(WIDTH, LAT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    localparam logic [CW-1:0] TC_VAL = CW'(WIDTH + LAT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge inputs regardless of process order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == TC_VAL);

endmodule

// File: rtl/siso_seq_ctrl.sv
// Parallel front-end for a LAT-stage serial DFF chain: serializes a word
// LSB-first, waits out the chain delay, and reassembles the returned bits.
module siso_seq_ctrl
    import siso_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LAT   = DEF_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             sout,
    input  logic             sin,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int CW = cnt_width(WIDTH, LAT);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH:0]   rx_cat;
    logic [CW-1:0]    cnt;
    logic             tc;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cap_en;

    siso_seq_cnt #(
        .WIDTH (WIDTH),
        .LAT   (LAT),
        .CW    (CW)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (cnt),
        .tc_o  (tc)
    );

    // Returned bits are valid once the first transmitted bit has crossed the chain.
    if (LAT == 0) begin : g_cap_always
        assign cap_en = 1'b1;
    end else begin : g_cap_after_lat
        assign cap_en = (cnt >= CW'(LAT));
    end

    // Concatenating sin above rx keeps the shift legal even for WIDTH=1.
    assign rx_cat = {sin, rx_q};

    // NOTE: every always_comb target gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        out_data_d = out_data_q;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    tx_d    = in_data;
                    rx_d    = '0;
                    cnt_clr = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                cnt_en = 1'b1;
                tx_d   = tx_q >> 1;
                if (cap_en) begin
                    rx_d = rx_cat[WIDTH:1];
                end
                if (tc) begin
                    out_data_d = rx_d;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            out_data_q <= out_data_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign out_valid = (state_q == DONE);
    assign sout      = (state_q == SHIFT && cnt < WIDTH_C) ? tx_q[0] : 1'b0;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_siso_seq_ctrl.sv
// Loopback bench: one controller drives a 4-DFF chain, a second one has
// sout wired straight to sin; expected words and bit streams come from the
// transmitted word itself.
module tb_siso_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid, in_ready, sout, sin, busy, out_valid, out_ready;
    logic [3:0] in_data, out_data;
    logic [3:0] chain;

    logic       in_valid0, in_ready0, sout0, busy0, out_valid0, out_ready0;
    logic [3:0] in_data0, out_data0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // External free-running 4-stage chain.
    always @(posedge clk) chain <= {chain[2:0], sout};
    assign sin = chain[3];

    siso_seq_ctrl #(.WIDTH(4), .LAT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sout      (sout),
        .sin       (sin),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    siso_seq_ctrl #(.WIDTH(4), .LAT(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .in_data   (in_data0),
        .sout      (sout0),
        .sin       (sout0),
        .busy      (busy0),
        .out_valid (out_valid0),
        .out_ready (out_ready0),
        .out_data  (out_data0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
            n_cmp++; if (sout !== 1'b0) begin n_err++; $display("FAIL rst_sout got=%b exp=0", sout); end
            n_cmp++; if (out_data !== 4'h0) begin n_err++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
            n_cmp++; if (in_ready0 !== 1'b1 || out_data0 !== 4'h0) begin n_err++; $display("FAIL rst_lat0 rdy=%b data=%h exp=1/0", in_ready0, out_data0); end
        end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_no_start busy=%b exp=0", busy); end
    endtask

    // One full transfer on the LAT=4 controller, with `stall` cycles of
    // out_ready low once the word is presented.
    task automatic xfer4(input logic [3:0] w, input int stall);
        logic exp_bit;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL xfer_idle in_ready=%b exp=1", in_ready); end
        in_data = w; in_valid = 1'b1; out_ready = (stall == 0);
        tick();
        in_valid = 1'b0; in_data = ~w;
        for (int k = 0; k < 8; k++) begin
            exp_bit = (k < 4) ? w[k] : 1'b0;
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL shift_busy k=%0d got=%b exp=1", k, busy); end
            n_cmp++; if (sout !== exp_bit) begin n_err++; $display("FAIL shift_sout k=%0d got=%b exp=%b", k, sout, exp_bit); end
            n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL shift_hs k=%0d valid=%b ready=%b exp=0/0", k, out_valid, in_ready); end
            tick();
        end
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid s=%0d got=%b exp=1", s, out_valid); end
            n_cmp++; if (out_data !== w) begin n_err++; $display("FAIL stall_data s=%0d got=%h exp=%h", s, out_data, w); end
            n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b0 || sout !== 1'b0) begin n_err++; $display("FAIL stall_ctrl s=%0d rdy=%b busy=%b sout=%b exp=0/0/0", s, in_ready, busy, sout); end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL done_valid got=%b exp=1", out_valid); end
        n_cmp++; if (out_data !== w) begin n_err++; $display("FAIL done_data got=%h exp=%h", out_data, w); end
        tick();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL post_idle valid=%b ready=%b exp=0/1", out_valid, in_ready); end
        n_cmp++; if (out_data !== w) begin n_err++; $display("FAIL post_hold got=%h exp=%h", out_data, w); end
    endtask

    task automatic test_loopback();
        xfer4(4'b1011, 0);
    endtask

    task automatic test_backpressure();
        xfer4(4'b0110, 5);
    endtask

    task automatic test_back_to_back();
        logic [3:0] got_q[$];
        int accept2 = -1;
        logic pre_ready;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 4'b1001;
        tick();
        in_data = 4'b0101;
        for (int i = 1; i <= 20; i++) begin
            pre_ready = in_ready;
            tick();
            if (pre_ready && in_valid && accept2 < 0) begin
                accept2 = i;
                in_valid = 1'b0;
            end
            if (out_valid) got_q.push_back(out_data);
        end
        n_cmp++; if (accept2 !== 10) begin n_err++; $display("FAIL b2b_spacing got=%0d exp=10", accept2); end
        n_cmp++; if (got_q.size() !== 2) begin n_err++; $display("FAIL b2b_count got=%0d exp=2", got_q.size()); end
        if (got_q.size() == 2) begin
            n_cmp++; if (got_q[0] !== 4'b1001) begin n_err++; $display("FAIL b2b_word0 got=%h exp=9", got_q[0]); end
            n_cmp++; if (got_q[1] !== 4'b0101) begin n_err++; $display("FAIL b2b_word1 got=%h exp=5", got_q[1]); end
        end
    endtask

    task automatic test_mid_reset();
        int seen_valid = 0;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 4'b0111;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_pre_busy got=%b exp=1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL mid_idle busy=%b ready=%b exp=0/1", busy, in_ready); end
        n_cmp++; if (out_data !== 4'h0) begin n_err++; $display("FAIL mid_data got=%h exp=0", out_data); end
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen_valid++;
            tick();
        end
        n_cmp++; if (seen_valid !== 0) begin n_err++; $display("FAIL mid_no_valid got=%0d exp=0", seen_valid); end
        xfer4(4'b1110, 0);
    endtask

    task automatic lat0_word(input logic [3:0] w);
        int n_busy = 0;
        logic got = 1'b0;
        logic [3:0] data = 4'h0;
        out_ready0 = 1'b1; in_valid0 = 1'b1; in_data0 = w;
        tick();
        in_valid0 = 1'b0; in_data0 = ~w;
        for (int i = 0; i < 12; i++) begin
            if (busy0) n_busy++;
            if (out_valid0 && !got) begin got = 1'b1; data = out_data0; end
            tick();
        end
        n_cmp++; if (n_busy !== 4) begin n_err++; $display("FAIL lat0_busy w=%h got=%0d exp=4", w, n_busy); end
        n_cmp++; if (got !== 1'b1 || data !== w) begin n_err++; $display("FAIL lat0_data got=%b/%h exp=1/%h", got, data, w); end
        n_cmp++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL lat0_idle got=%b exp=1", in_ready0); end
    endtask

    task automatic test_lat0();
        lat0_word(4'b0011);
        for (int i = 0; i < 4; i++) lat0_word(4'($urandom));
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) xfer4(4'($urandom), int'($urandom_range(0, 3)));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b1;
        in_valid0 = 1'b0; in_data0 = 4'h0; out_ready0 = 1'b1;
        test_reset();
        test_loopback();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_lat0();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
